// File: rtl/alu8_seq_ctrl.sv
// alu8_seq_ctrl: runs 8-bit commands on a 4-bit ALU as one or two nibble passes (carry chained
// low to high) and returns an 8-bit result with flags on a valid/ready response channel.
module alu8_seq_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_oc,
  output logic       alu_cry_in,
  input  logic [7:0] alu_c,
  input  logic       alu_cry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_cry,
  output logic       rsp_brr,
  output logic       rsp_zro,
  output logic       rsp_neg
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;
  typedef enum logic [2:0] {
    OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_NEG, OP_MUL
  } op_t;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oc;
    logic       cry_in;
  } pass_t;

  state_t        state, state_next;
  op_t           op_q;
  logic [7:0]    a_q, b_q;
  logic [3:0]    lo_c;
  logic [CW-1:0] cnt;
  logic          pass_last, finish;
  logic [7:0]    res_d;

  // ALU drive for one nibble pass. SUB/NEG become A + ~B + 1 so opcodes 5/6 are never issued.
  function automatic pass_t pass_vals(op_t op, logic [7:0] a, logic [7:0] b, logic hi, logic cin);
    logic [3:0] an, bn;
    pass_t      p;
    an = hi ? a[7:4] : a[3:0];
    bn = hi ? b[7:4] : b[3:0];
    p  = '0;
    case (op)
      OP_NOT:                begin p.oc = 3'd0; p.a = an; end
      OP_AND, OP_OR, OP_XOR: begin p.oc = op;   p.a = an; p.b = bn; end
      OP_ADD:                begin p.oc = 3'd4; p.a = an; p.b = bn;  p.cry_in = hi & cin; end
      OP_SUB, OP_NEG:        begin p.oc = 3'd4; p.a = an; p.b = ~bn; p.cry_in = hi ? cin : 1'b1; end
      OP_MUL:                begin p.oc = 3'd7; p.a = a[3:0]; p.b = b[3:0]; end
      default:               p = '0;
    endcase
    return p;
  endfunction

  assign pass_last = (cnt == CNT_LAST);
  assign finish    = pass_last && ((state == HI) || (state == LO && op_q == OP_MUL));
  assign res_d     = (op_q == OP_MUL) ? alu_c : {alu_c[3:0], lo_c};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_next = LO;
      LO:      if (pass_last) state_next = (op_q == OP_MUL) ? RSP : HI;
      HI:      if (pass_last) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Command latch, pass counter and ALU drive. A pass's first LO cycle only launches the
  // operands; capture happens after SETTLE held cycles, and HI launches on the LO capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready                              <= 1'b0;
      op_q                                   <= OP_NOT;
      a_q                                    <= '0;
      b_q                                    <= '0;
      lo_c                                   <= '0;
      cnt                                    <= '0;
      {alu_a, alu_b, alu_oc, alu_cry_in}     <= '0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          op_q <= op_t'(cmd_op);
          a_q  <= (op_t'(cmd_op) == OP_NEG) ? 8'h00 : cmd_a;
          b_q  <= (op_t'(cmd_op) == OP_NEG) ? cmd_a : cmd_b;
          cnt  <= '0;
        end
        LO: begin
          if (cnt == '0) begin
            {alu_a, alu_b, alu_oc, alu_cry_in} <= pass_vals(op_q, a_q, b_q, 1'b0, 1'b0);
            cnt <= CNT_ONE;
          end else if (pass_last) begin
            lo_c <= alu_c[3:0];
            if (op_q == OP_MUL) begin
              {alu_a, alu_b, alu_oc, alu_cry_in} <= '0;
            end else begin
              {alu_a, alu_b, alu_oc, alu_cry_in} <= pass_vals(op_q, a_q, b_q, 1'b1, alu_cry);
              cnt <= CNT_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HI: begin
          if (pass_last) {alu_a, alu_b, alu_oc, alu_cry_in} <= '0;
          else           cnt <= cnt + CNT_ONE;
        end
        default: {alu_a, alu_b, alu_oc, alu_cry_in} <= '0;
      endcase
    end
  end

  // Response registers hold while the consumer stalls and clear on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rsp_valid, rsp_result, rsp_cry, rsp_brr, rsp_zro, rsp_neg} <= '0;
    end else if (finish) begin
      rsp_valid  <= 1'b1;
      rsp_result <= res_d;
      rsp_cry    <= (op_q == OP_ADD) & alu_cry;
      rsp_brr    <= ((op_q == OP_SUB) || (op_q == OP_NEG)) & ~alu_cry;
      rsp_zro    <= (res_d == 8'h00);
      rsp_neg    <= op_q[2] & res_d[7];
    end else if (state == RSP && rsp_ready) begin
      {rsp_valid, rsp_result, rsp_cry, rsp_brr, rsp_zro, rsp_neg} <= '0;
    end
  end

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Bench for alu8_seq_ctrl: two instances (SETTLE=1 and SETTLE=3), each paired with a 4-bit ALU
// model, checked against a plain-arithmetic 8-bit reference.
module tb_alu8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid [2];
  logic [2:0] cmd_op    [2];
  logic [7:0] cmd_a     [2];
  logic [7:0] cmd_b     [2];
  logic       rsp_ready [2];
  logic       cmd_ready [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [2:0] alu_oc    [2];
  logic       alu_cry_in[2];
  logic [7:0] alu_c     [2];
  logic       alu_cry   [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_result[2];
  logic       rsp_cry   [2];
  logic       rsp_brr   [2];
  logic       rsp_zro   [2];
  logic       rsp_neg   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int bad_oc   = 0;

  // 4-bit ALU: {cry, c[7:0]}
  function automatic logic [8:0] alu_model(logic [2:0] oc, logic [3:0] a, logic [3:0] b, logic cin);
    logic [4:0] s;
    case (oc)
      3'd0:    return {5'b0, ~a};
      3'd1:    return {5'b0, a & b};
      3'd2:    return {5'b0, a | b};
      3'd3:    return {5'b0, a ^ b};
      3'd4:    begin s = {1'b0, a} + {1'b0, b} + {4'b0, cin}; return {s[4], 4'b0, s[3:0]}; end
      3'd7:    return {1'b0, 8'(a) * 8'(b)};
      default: return 9'h1A5;
    endcase
  endfunction

  // Reference: {neg, zro, brr, cry, result}
  function automatic logic [11:0] ref_op(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cry, brr;
    cry = 1'b0;
    brr = 1'b0;
    r   = 8'h00;
    case (op)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cry = s[8]; end
      3'd5: begin r = a - b; brr = (a < b); end
      3'd6: begin r = 8'h00 - a; brr = (a != 8'h00); end
      default: r = 8'(a[3:0]) * 8'(b[3:0]);
    endcase
    return {(op >= 3'd4) && r[7], r == 8'h00, brr, cry, r};
  endfunction

  function automatic logic [25:0] out_bits(int u);
    return {cmd_ready[u], alu_a[u], alu_b[u], alu_oc[u], alu_cry_in[u], rsp_valid[u],
            rsp_result[u], rsp_cry[u], rsp_brr[u], rsp_zro[u], rsp_neg[u]};
  endfunction

  function automatic logic [11:0] rsp_bits(int u);
    return {rsp_neg[u], rsp_zro[u], rsp_brr[u], rsp_cry[u], rsp_result[u]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : unit
    alu8_seq_ctrl #(.SETTLE(g == 0 ? 1 : 3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_op     (cmd_op[g]),
      .cmd_a      (cmd_a[g]),
      .cmd_b      (cmd_b[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_oc     (alu_oc[g]),
      .alu_cry_in (alu_cry_in[g]),
      .alu_c      (alu_c[g]),
      .alu_cry    (alu_cry[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_cry    (rsp_cry[g]),
      .rsp_brr    (rsp_brr[g]),
      .rsp_zro    (rsp_zro[g]),
      .rsp_neg    (rsp_neg[g])
    );
    assign {alu_cry[g], alu_c[g]} = alu_model(alu_oc[g], alu_a[g], alu_b[g], alu_cry_in[g]);
  end

  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (alu_oc[g] == 3'd5 || alu_oc[g] == 3'd6) bad_oc++;

  // Issue one command on unit u, check latency, result/flags, idle ALU drive and the handshake.
  // With hold > 0 the response is stalled for that many cycles while cmd_valid is pulsed.
  task automatic do_op(input int u, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input string tag);
    int          settle, lat_exp, lat, waited;
    logic [11:0] e;
    settle  = (u == 0) ? 1 : 3;
    lat_exp = (op == 3'd7) ? settle + 1 : 2 * settle + 1;
    e       = ref_op(op, a, b);
    @(negedge clk);
    waited = 0;
    while (cmd_ready[u] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready[u] !== 1'b1) begin
      n_checks++;
      $display("FAIL %s cmd_ready: got %b want 1 within 50 cycles", tag, cmd_ready[u]);
      return;
    end
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_a[u]     = a;
    cmd_b[u]     = b;
    @(posedge clk);
    #1;
    cmd_valid[u] = 1'b0;
    cmd_a[u]     = 8'($urandom);
    cmd_b[u]     = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (rsp_valid[u] !== 1'b1 && lat < 40);

    n_checks++;
    if (lat !== lat_exp) $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp);
    else n_pass++;
    n_checks++;
    if (rsp_bits(u) !== e)
      $display("FAIL %s op%0d a=%h b=%h {neg,zro,brr,cry,res}: got %b_%h want %b_%h", tag, op, a, b,
               rsp_bits(u) >> 8, rsp_result[u], e >> 8, e[7:0]);
    else n_pass++;
    n_checks++;
    if ({alu_a[u], alu_b[u], alu_oc[u], alu_cry_in[u], cmd_ready[u]} !== 13'h0)
      $display("FAIL %s alu/cmd_ready idle in RSP: got %h want 0", tag,
               {alu_a[u], alu_b[u], alu_oc[u], alu_cry_in[u], cmd_ready[u]});
    else n_pass++;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid[u] = 1'b1;
      cmd_op[u]    = 3'($urandom);
      cmd_a[u]     = 8'($urandom);
      n_checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_bits(u) !== e || cmd_ready[u] !== 1'b0)
        $display("FAIL %s stall cycle %0d: got v%b rdy%b %h want v1 rdy0 %h", tag, i,
                 rsp_valid[u], cmd_ready[u], rsp_bits(u), e);
      else n_pass++;
    end

    @(negedge clk);
    cmd_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid[u] !== 1'b0 || cmd_ready[u] !== 1'b1)
      $display("FAIL %s handshake: got rsp_valid=%b cmd_ready=%b want 0/1", tag,
               rsp_valid[u], cmd_ready[u]);
    else n_pass++;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (out_bits(u) !== 26'h0) $display("FAIL reset u%0d outputs: got %h want 0", u, out_bits(u));
      else n_pass++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (cmd_ready[u] !== 1'b1) $display("FAIL reset u%0d cmd_ready after release: got %b want 1", u, cmd_ready[u]);
      else n_pass++;
    end
  endtask

  task automatic test_directed(input int u);
    do_op(u, 3'd4, 8'h7F, 8'h01, 0, "add_7f_01");
    do_op(u, 3'd4, 8'hFF, 8'h01, 0, "add_ff_01");
    do_op(u, 3'd5, 8'h05, 8'h07, 0, "sub_05_07");
    do_op(u, 3'd5, 8'h07, 8'h05, 0, "sub_07_05");
    do_op(u, 3'd6, 8'h01, 8'h00, 0, "neg_01");
    do_op(u, 3'd6, 8'h80, 8'h33, 0, "neg_80");
    do_op(u, 3'd6, 8'h00, 8'hFF, 0, "neg_00");
    do_op(u, 3'd7, 8'h0F, 8'h0F, 0, "mul_0f_0f");
    do_op(u, 3'd3, 8'hA5, 8'hFF, 0, "xor_a5_ff");
    do_op(u, 3'd0, 8'h0F, 8'h00, 0, "not_0f");
  endtask

  task automatic test_back_to_back(input int u);
    do_op(u, 3'd4, 8'h3C, 8'h5A, 5, "stall_add");
    do_op(u, 3'd1, 8'hF0, 8'h3C, 0, "after_stall_and");
  endtask

  task automatic test_random(input int u, input int n);
    for (int i = 0; i < n; i++)
      do_op(u, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, "random");
  endtask

  task automatic test_reset_mid_hi();
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 3'd4;
    cmd_a[0]     = 8'h12;
    cmd_b[0]     = 8'h34;
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({alu_a[0], alu_b[0], alu_oc[0]} !== {4'h1, 4'h3, 3'd4})
      $display("FAIL mid_hi drive: got %h want %h", {alu_a[0], alu_b[0], alu_oc[0]}, {4'h1, 4'h3, 3'd4});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_bits(0) !== 26'h0) $display("FAIL mid_hi async reset: got %h want 0", out_bits(0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 3'd4, 8'h10, 8'h20, 0, "post_reset_add");
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0;
      cmd_op[u]    = 3'd0;
      cmd_a[u]     = 8'h00;
      cmd_b[u]     = 8'h00;
      rsp_ready[u] = 1'b0;
    end
    test_reset();
    test_directed(0);
    test_back_to_back(0);
    test_random(0, 25);
    test_reset_mid_hi();
    test_directed(1);
    test_back_to_back(1);
    test_random(1, 15);
    n_checks++;
    if (bad_oc !== 0) $display("FAIL alu_oc 5/6 seen: got %0d cycles want 0", bad_oc);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
